calc_seq_ctrl: RTL and testbench
================================

Name: calc_seq_ctrl

Overview:
Sequencing controller for the 16-bit calculator datapath on the 4-digit seven-segment board. It turns debounced button levels and switch settings into operand entry, an operation code, and an ALU start/done handshake. It also drives a single display word plus a digit-enable mask for the shared display module. It sits between the pbdebounce outputs and the ALU/display.

Parameters:
DATA_W, 16, operand/result width (multiple of 4)
BLINK_DIV, 25_000_000, clk cycles per blink phase toggle
ALU_TMO, 1024, max cycles in WAIT before error
IDLE_TMO, 500_000_000, cycles of no button activity before return to IDLE

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
btn  in  4  debounced button levels: [0] next, [1] back, [2] shift-in, [3] clear
switch  in  8  [3:0] entry nibble, [5:4] op select, [7:6] unused
alu_result  in  DATA_W  ALU result
alu_done  in  1  one-cycle pulse, result valid
alu_start  out  1  one-cycle start pulse
op_code  out  2  latched operation
op1  out  DATA_W  operand A register
op2  out  DATA_W  operand B register
disp_num  out  DATA_W  word to display
disp_en  out  4  digit enable mask
busy  out  1  high in EXEC/WAIT
err  out  1  sticky ALU timeout flag, cleared on leaving SHOW

Behaviour:
- Reset (async, any state): state=IDLE; op1=op2=0; op_code=0; alu_start=0; disp_num=0; disp_en=4'b1111; busy=0; err=0; blink and timeout counters=0; edge-detect history=0.
- Buttons: rising-edge detect on each btn bit gives a 1-cycle pulse, 1 cycle after the level rises. A held level produces no repeat.
- Same-cycle priority: clear > back > next > shift. Only the winning pulse acts.
- States: IDLE, ENT_A, ENT_B, EXEC, WAIT, SHOW.
- IDLE: disp_num=0. next -> ENT_A.
- ENT_A: shift -> op1 = {op1[DATA_W-5:0], switch[3:0]}. next -> ENT_B. back -> IDLE. disp_num=op1.
- ENT_B: same entry rule on op2. next -> EXEC. back -> ENT_A, op2 kept. disp_num=op2.
- EXEC: op_code<=switch[5:4]; alu_start=1 for exactly this one cycle; -> WAIT next cycle. disp_num holds op2.
- WAIT: alu_done -> result register <= alu_result, -> SHOW. After ALU_TMO cycles without done -> SHOW with err=1 and result register = all nibbles 4'hE.
- SHOW: disp_num = result register. next -> ENT_A with op1=op2=0. back -> ENT_B.
- clear in any state except EXEC/WAIT: op1=op2=0, -> IDLE. In EXEC/WAIT, clear is ignored; busy=1 there and all buttons are ignored.
- alu_done outside WAIT is ignored.
- Blink: in ENT_A/ENT_B, disp_en[0] toggles every BLINK_DIV cycles, upper bits =1. Elsewhere disp_en=4'b1111. The blink counter restarts on every state change, with phase on.
- Idle timeout: IDLE_TMO cycles with no button pulse in ENT_A, ENT_B or SHOW -> IDLE, operands cleared. Any pulse restarts the count. No timeout in EXEC/WAIT.
- All outputs registered, except alu_start, which is decoded from state==EXEC.

Optional Feature:
RESULT_CHAIN_EN
- Defined: next in SHOW loads op1 <= result register, clears op2, -> ENT_B, allowing chained operations. An err result is not chained: op1 is cleared and the state goes to ENT_A.
- Undefined: next in SHOW behaves as in Behaviour.

Decomposition:
- Shared package calc_pkg: state enum (6 codes, 3 bits), op_code constants OP_ADD=0, OP_SUB=1, OP_AND=2, OP_OR=3, button index constants, error pattern constant.
- One sub-module: btn_edge (4-bit rising-edge pulse generator, async reset).

Test Plan:
- Reset mid-WAIT: assert rst -> state IDLE, op1=op2=0, disp_en=4'hF, busy=0 immediately, without waiting for a clock edge.
- Entry: next; shift with switch=1,2,3,4; next; shift with 0,0,0,5 -> op1=16'h1234, op2=16'h0005, disp_num tracks each register one cycle after each pulse.
- Handshake: switch[5:4]=0, next -> one-cycle alu_start, op_code=0, busy=1; alu_done with 16'h1239 after 3 cycles -> SHOW, disp_num=16'h1239, busy=0.
- Timeout: no alu_done for ALU_TMO cycles -> err=1, disp_num=16'hEEEE; next -> err=0, ENT_A.
- Simultaneous: clear+next pulse in ENT_B -> IDLE with operands zero. Held next level -> exactly one transition. alu_done pulse in IDLE -> no change.
- Blink: in ENT_A with BLINK_DIV=4 -> disp_en alternates 4'hF/4'hE every 4 cycles. In SHOW -> constant 4'hF.

Source files
------------

// File: rtl/calc_pkg.sv
`default_nettype none
// ============================================================================
// Package  : calc_pkg
// Brief    : Shared state, op-code, button-index and error-pattern definitions
//            for the calculator sequencing controller.
// Revision : 1.0 - initial release
// ============================================================================
package calc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ENT_A = 3'd1,
        ST_ENT_B = 3'd2,
        ST_EXEC  = 3'd3,
        ST_WAIT  = 3'd4,
        ST_SHOW  = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_AND = 2'd2,
        OP_OR  = 2'd3
    } op_t;

    localparam int BTN_NEXT  = 0;
    localparam int BTN_BACK  = 1;
    localparam int BTN_SHIFT = 2;
    localparam int BTN_CLEAR = 3;

    // Replicated across every nibble of the result on an ALU timeout.
    localparam logic [3:0] ERR_NIBBLE = 4'hE;

endpackage
`default_nettype wire

// File: rtl/btn_edge.sv
`default_nettype none
// ============================================================================
// Module   : btn_edge
// Brief    : Per-bit rising-edge detector; registered one-cycle pulse per rise.
// Revision : 1.0 - initial release
// ============================================================================
module btn_edge #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_level,
    output logic [WIDTH-1:0] o_pulse
);

    logic [WIDTH-1:0] r_hist;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hist  <= '0;
            o_pulse <= '0;
        end else begin
            r_hist  <= i_level;
            o_pulse <= i_level & ~r_hist;
        end
    end

endmodule
`default_nettype wire

// File: rtl/calc_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : calc_seq_ctrl
// Brief    : Operand entry / ALU handshake / display sequencer for the 16-bit
//            calculator. Define RESULT_CHAIN_EN to chain results into op1.
// Revision : 1.0 - initial release
// ============================================================================
module calc_seq_ctrl
    import calc_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int BLINK_DIV = 25_000_000,
    parameter int ALU_TMO   = 1024,
    parameter int IDLE_TMO  = 500_000_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        btn,
    input  logic [7:0]        switch,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_done,
    output logic              alu_start,
    output logic [1:0]        op_code,
    output logic [DATA_W-1:0] op1,
    output logic [DATA_W-1:0] op2,
    output logic [DATA_W-1:0] disp_num,
    output logic [3:0]        disp_en,
    output logic              busy,
    output logic              err
);

    localparam int c_BLINK_W = $clog2(BLINK_DIV + 1);
    localparam int c_TMO_W   = $clog2(ALU_TMO + 1);
    localparam int c_IDLE_W  = $clog2(IDLE_TMO + 1);

    localparam logic [c_BLINK_W-1:0] c_BLINK_LAST = c_BLINK_W'(BLINK_DIV - 1);
    localparam logic [c_TMO_W-1:0]   c_TMO_LAST   = c_TMO_W'(ALU_TMO - 1);
    localparam logic [c_IDLE_W-1:0]  c_IDLE_LAST  = c_IDLE_W'(IDLE_TMO - 1);
    localparam logic [DATA_W-1:0]    c_ERR_WORD   = {(DATA_W / 4){ERR_NIBBLE}};

    state_t               r_state;
    state_t               w_state_nxt;
    logic [DATA_W-1:0]    r_result;
    logic [DATA_W-1:0]    w_result_nxt;
    logic [DATA_W-1:0]    w_op1_nxt;
    logic [DATA_W-1:0]    w_op2_nxt;
    logic [DATA_W-1:0]    w_disp_nxt;
    logic                 w_err_set;
    logic [c_BLINK_W-1:0] r_blink_cnt;
    logic [c_BLINK_W-1:0] w_blink_cnt_nxt;
    logic                 r_blink_ph;
    logic                 w_blink_ph_nxt;
    logic [c_TMO_W-1:0]   r_tmo_cnt;
    logic [c_IDLE_W-1:0]  r_idle_cnt;

    logic [3:0] w_pulse;
    logic       w_clr;
    logic       w_back;
    logic       w_next;
    logic       w_shift;
    logic       w_any_pulse;
    logic       w_busy_st;
    logic       w_entry_st;
    logic       w_blink_st;
    logic       w_idle_exp;
    logic       w_unused_sw;

    btn_edge #(
        .WIDTH (4)
    ) u_btn_edge (
        .clk     (clk),
        .rst     (rst),
        .i_level (btn),
        .o_pulse (w_pulse)
    );

    // Only the highest-priority pulse of a cycle is allowed to act.
    assign w_clr   = w_pulse[BTN_CLEAR];
    assign w_back  = w_pulse[BTN_BACK] & ~w_clr;
    assign w_next  = w_pulse[BTN_NEXT] & ~w_pulse[BTN_BACK] & ~w_clr;
    assign w_shift = w_pulse[BTN_SHIFT] & ~w_pulse[BTN_NEXT] & ~w_pulse[BTN_BACK] & ~w_clr;
    assign w_any_pulse = |w_pulse;

    assign w_busy_st  = (r_state == ST_EXEC) || (r_state == ST_WAIT);
    assign w_blink_st = (r_state == ST_ENT_A) || (r_state == ST_ENT_B);
    assign w_entry_st = w_blink_st || (r_state == ST_SHOW);
    assign w_idle_exp = w_entry_st && !w_any_pulse && (r_idle_cnt == c_IDLE_LAST);

    assign alu_start   = (r_state == ST_EXEC);
    assign w_unused_sw = ^switch[7:6];

    always_comb begin
        w_state_nxt  = r_state;
        w_op1_nxt    = op1;
        w_op2_nxt    = op2;
        w_result_nxt = r_result;
        w_err_set    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_next) w_state_nxt = ST_ENT_A;
            end
            ST_ENT_A: begin
                if (w_back)       w_state_nxt = ST_IDLE;
                else if (w_next)  w_state_nxt = ST_ENT_B;
                else if (w_shift) w_op1_nxt   = {op1[DATA_W-5:0], switch[3:0]};
            end
            ST_ENT_B: begin
                if (w_back)       w_state_nxt = ST_ENT_A;
                else if (w_next)  w_state_nxt = ST_EXEC;
                else if (w_shift) w_op2_nxt   = {op2[DATA_W-5:0], switch[3:0]};
            end
            ST_EXEC: begin
                w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (alu_done) begin
                    w_result_nxt = alu_result;
                    w_state_nxt  = ST_SHOW;
                end else if (r_tmo_cnt == c_TMO_LAST) begin
                    w_result_nxt = c_ERR_WORD;
                    w_err_set    = 1'b1;
                    w_state_nxt  = ST_SHOW;
                end
            end
            ST_SHOW: begin
                if (w_back) begin
                    w_state_nxt = ST_ENT_B;
                end else if (w_next) begin
`ifdef RESULT_CHAIN_EN
                    w_op2_nxt = '0;
                    if (err) begin
                        w_op1_nxt   = '0;
                        w_state_nxt = ST_ENT_A;
                    end else begin
                        w_op1_nxt   = r_result;
                        w_state_nxt = ST_ENT_B;
                    end
`else
                    w_op1_nxt   = '0;
                    w_op2_nxt   = '0;
                    w_state_nxt = ST_ENT_A;
`endif
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        if (w_idle_exp || (w_clr && !w_busy_st)) begin
            w_state_nxt = ST_IDLE;
            w_op1_nxt   = '0;
            w_op2_nxt   = '0;
        end
    end

    // Blink restarts on every state change with the digit lit.
    always_comb begin
        w_blink_cnt_nxt = '0;
        w_blink_ph_nxt  = 1'b1;
        if ((w_state_nxt == r_state) && w_blink_st) begin
            if (r_blink_cnt == c_BLINK_LAST) begin
                w_blink_ph_nxt = ~r_blink_ph;
            end else begin
                w_blink_cnt_nxt = r_blink_cnt + c_BLINK_W'(1);
                w_blink_ph_nxt  = r_blink_ph;
            end
        end
    end

    always_comb begin
        case (w_state_nxt)
            ST_IDLE:  w_disp_nxt = '0;
            ST_ENT_A: w_disp_nxt = w_op1_nxt;
            ST_SHOW:  w_disp_nxt = w_result_nxt;
            default:  w_disp_nxt = w_op2_nxt;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            op1         <= '0;
            op2         <= '0;
            r_result    <= '0;
            op_code     <= OP_ADD;
            disp_num    <= '0;
            disp_en     <= 4'b1111;
            busy        <= 1'b0;
            err         <= 1'b0;
            r_blink_cnt <= '0;
            r_blink_ph  <= 1'b1;
            r_tmo_cnt   <= '0;
            r_idle_cnt  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            op1         <= w_op1_nxt;
            op2         <= w_op2_nxt;
            r_result    <= w_result_nxt;
            disp_num    <= w_disp_nxt;
            busy        <= (w_state_nxt == ST_EXEC) || (w_state_nxt == ST_WAIT);
            r_blink_cnt <= w_blink_cnt_nxt;
            r_blink_ph  <= w_blink_ph_nxt;

            // Latched on entry so the code is stable while alu_start is high.
            if (w_state_nxt == ST_EXEC) op_code <= switch[5:4];

            if ((w_state_nxt == ST_ENT_A) || (w_state_nxt == ST_ENT_B))
                disp_en <= {3'b111, w_blink_ph_nxt};
            else
                disp_en <= 4'b1111;

            if (w_err_set)
                err <= 1'b1;
            else if ((r_state == ST_SHOW) && (w_state_nxt != ST_SHOW))
                err <= 1'b0;

            if ((r_state == ST_WAIT) && (w_state_nxt == ST_WAIT))
                r_tmo_cnt <= r_tmo_cnt + c_TMO_W'(1);
            else
                r_tmo_cnt <= '0;

            if (!w_entry_st || w_any_pulse || (w_state_nxt != r_state))
                r_idle_cnt <= '0;
            else
                r_idle_cnt <= r_idle_cnt + c_IDLE_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_calc_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_calc_seq_ctrl
// Brief    : Scoreboard bench for calc_seq_ctrl with short blink/timeout values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_calc_seq_ctrl;
    import calc_pkg::*;

    localparam int DATA_W    = 16;
    localparam int BLINK_DIV = 4;
    localparam int ALU_TMO   = 16;
    localparam int IDLE_TMO  = 200;

    localparam logic [3:0] B_NEXT  = 4'b0001;
    localparam logic [3:0] B_BACK  = 4'b0010;
    localparam logic [3:0] B_SHIFT = 4'b0100;
    localparam logic [3:0] B_CLR   = 4'b1000;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [3:0]        btn = '0;
    logic [7:0]        switch = '0;
    logic [DATA_W-1:0] alu_result = '0;
    logic              alu_done = 1'b0;
    logic              alu_start;
    logic [1:0]        op_code;
    logic [DATA_W-1:0] op1;
    logic [DATA_W-1:0] op2;
    logic [DATA_W-1:0] disp_num;
    logic [3:0]        disp_en;
    logic              busy;
    logic              err;

    int n_vec = 0;
    int n_err = 0;

    logic [33:0]       q_start[$];
    logic [DATA_W-1:0] q_disp[$];
    logic [DATA_W-1:0] prev_disp = '0;

    always #5 clk = ~clk;

    calc_seq_ctrl #(
        .DATA_W    (DATA_W),
        .BLINK_DIV (BLINK_DIV),
        .ALU_TMO   (ALU_TMO),
        .IDLE_TMO  (IDLE_TMO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn        (btn),
        .switch     (switch),
        .alu_result (alu_result),
        .alu_done   (alu_done),
        .alu_start  (alu_start),
        .op_code    (op_code),
        .op1        (op1),
        .op2        (op2),
        .disp_num   (disp_num),
        .disp_en    (disp_en),
        .busy       (busy),
        .err        (err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every alu_start cycle and every change of disp_num consume one
    // expected entry pushed by the stimulus.
    always @(negedge clk) begin
        logic [33:0]       e_start;
        logic [DATA_W-1:0] e_disp;
        if (alu_start === 1'b1) begin
            n_vec++;
            if (q_start.size() == 0) begin
                n_err++;
                $display("FAIL start_seq: unexpected alu_start op=%h a=%h b=%h", op_code, op1, op2);
            end else begin
                e_start = q_start.pop_front();
                if ({op_code, op1, op2} !== e_start) begin
                    n_err++;
                    $display("FAIL start_seq: got %h expected %h", {op_code, op1, op2}, e_start);
                end
            end
        end
        if (disp_num !== prev_disp) begin
            n_vec++;
            if (q_disp.size() == 0) begin
                n_err++;
                $display("FAIL disp_seq: unexpected change to %h", disp_num);
            end else begin
                e_disp = q_disp.pop_front();
                if (disp_num !== e_disp) begin
                    n_err++;
                    $display("FAIL disp_seq: got %h expected %h", disp_num, e_disp);
                end
            end
            prev_disp = disp_num;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Returns 1 time unit after the edge on which the FSM acts on the press.
    task automatic press_sync(input logic [3:0] b);
        @(posedge clk);
        #1;
        btn = b;
        @(posedge clk);
        @(posedge clk);
        #1;
        btn = '0;
    endtask

    task automatic press(input logic [3:0] b);
        press_sync(b);
        tick(1);
    endtask

    task automatic shift_nib(input logic [3:0] nib);
        switch[3:0] = nib;
        press(B_SHIFT);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] exp_v;
        logic [3:0]  nibs_a[4];
        logic [3:0]  nibs_b[4];
        nibs_a = '{4'h1, 4'h2, 4'h3, 4'h4};
        nibs_b = '{4'h0, 4'h0, 4'h0, 4'h5};

        // Reset values
        tick(3);
        chk("rst_disp", disp_num, 16'h0000);
        chk("rst_en", disp_en, 4'hF);
        chk("rst_busy", busy, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_op1", op1, 16'h0000);
        chk("rst_op2", op2, 16'h0000);
        chk("rst_start", alu_start, 1'b0);
        chk("rst_opcode", op_code, 2'd0);
        rst = 1'b0;
        tick(2);

        // Operand entry
        press(B_NEXT);
        exp_v = 16'h0000;
        for (int i = 0; i < 4; i++) begin
            exp_v = {exp_v[11:0], nibs_a[i]};
            q_disp.push_back(exp_v);
            shift_nib(nibs_a[i]);
            chk("entry_op1", op1, exp_v);
            chk("entry_disp_a", disp_num, exp_v);
        end
        q_disp.push_back(16'h0000);
        press(B_NEXT);
        exp_v = 16'h0000;
        for (int i = 0; i < 4; i++) begin
            if ({exp_v[11:0], nibs_b[i]} != exp_v) q_disp.push_back({exp_v[11:0], nibs_b[i]});
            exp_v = {exp_v[11:0], nibs_b[i]};
            shift_nib(nibs_b[i]);
            chk("entry_op2", op2, exp_v);
            chk("entry_disp_b", disp_num, exp_v);
        end
        chk("entry_final_op1", op1, 16'h1234);
        chk("entry_final_op2", op2, 16'h0005);

        // ALU handshake
        switch = 8'h00;
        q_start.push_back({2'd0, 16'h1234, 16'h0005});
        press_sync(B_NEXT);
        chk("exec_start", alu_start, 1'b1);
        chk("exec_busy", busy, 1'b1);
        chk("exec_opcode", op_code, 2'd0);
        tick(1);
        chk("wait_start_low", alu_start, 1'b0);
        chk("wait_busy", busy, 1'b1);
        tick(2);
        alu_result = 16'h1239;
        alu_done   = 1'b1;
        q_disp.push_back(16'h1239);
        tick(1);
        alu_done = 1'b0;
        chk("show_busy", busy, 1'b0);
        chk("show_disp", disp_num, 16'h1239);
        chk("show_err", err, 1'b0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("show_en_const", disp_en, 4'hF);
        end

        // SHOW -> ENT_A, then blink pattern from the state-change edge
        q_disp.push_back(16'h0000);
        press_sync(B_NEXT);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk($sformatf("blink_%0d", i), disp_en, ((i / 4) % 2 == 0) ? 4'hF : 4'hE);
        end
        chk("next_clr_op1", op1, 16'h0000);
        chk("next_clr_op2", op2, 16'h0000);

        // ALU timeout, with a clear press ignored during WAIT
        q_disp.push_back(16'h0001);
        shift_nib(4'h1);
        q_disp.push_back(16'h0000);
        press(B_NEXT);
        q_disp.push_back(16'h0002);
        shift_nib(4'h2);
        switch = 8'h20;
        q_start.push_back({2'd2, 16'h0001, 16'h0002});
        q_disp.push_back(16'hEEEE);
        press_sync(B_NEXT);
        for (int k = 0; k < ALU_TMO; k++) begin
            @(posedge clk);
            #1;
            if (k == 3) btn = B_CLR;
            if (k == 6) btn = '0;
        end
        chk("tmo_busy_before", busy, 1'b1);
        chk("tmo_err_before", err, 1'b0);
        chk("tmo_clr_ignored", op1, 16'h0001);
        tick(1);
        chk("tmo_busy_after", busy, 1'b0);
        chk("tmo_err_after", err, 1'b1);
        chk("tmo_disp", disp_num, 16'hEEEE);
        q_disp.push_back(16'h0000);
        press(B_NEXT);
        chk("tmo_err_cleared", err, 1'b0);
        chk("tmo_op1_cleared", op1, 16'h0000);

        // Clear + next in ENT_B
        switch = 8'h00;
        q_disp.push_back(16'h0007);
        shift_nib(4'h7);
        q_disp.push_back(16'h0000);
        press(B_NEXT);
        q_disp.push_back(16'h0009);
        shift_nib(4'h9);
        q_disp.push_back(16'h0000);
        press(B_CLR | B_NEXT);
        chk("simul_op1", op1, 16'h0000);
        chk("simul_op2", op2, 16'h0000);
        shift_nib(4'h3);
        chk("idle_shift_ignored", op1, 16'h0000);

        // Held next produces a single transition
        @(posedge clk);
        #1;
        btn = B_NEXT;
        tick(10);
        btn = '0;
        tick(2);
        q_disp.push_back(16'h0006);
        shift_nib(4'h6);
        chk("held_op1", op1, 16'h0006);
        chk("held_op2", op2, 16'h0000);

        // alu_done in IDLE is ignored
        q_disp.push_back(16'h0000);
        press(B_CLR);
        alu_result = 16'hBEEF;
        @(posedge clk);
        #1;
        alu_done = 1'b1;
        tick(1);
        alu_done = 1'b0;
        tick(2);
        chk("idle_done_disp", disp_num, 16'h0000);
        chk("idle_done_busy", busy, 1'b0);
        press(B_NEXT);
        q_disp.push_back(16'h0008);
        shift_nib(4'h8);
        chk("idle_done_op1", op1, 16'h0008);

        // back from ENT_B keeps op2
        q_disp.push_back(16'h0000);
        press(B_NEXT);
        q_disp.push_back(16'h0004);
        shift_nib(4'h4);
        q_disp.push_back(16'h0008);
        press(B_BACK);
        chk("back_op2_kept", op2, 16'h0004);
        chk("back_disp", disp_num, 16'h0008);
        q_disp.push_back(16'h0004);
        press(B_NEXT);
        chk("back_next_disp", disp_num, 16'h0004);

        // Idle timeout boundary
        tick(IDLE_TMO - 2);
        chk("idle_tmo_before", op2, 16'h0004);
        q_disp.push_back(16'h0000);
        tick(1);
        chk("idle_tmo_op1", op1, 16'h0000);
        chk("idle_tmo_op2", op2, 16'h0000);

        // Asynchronous reset in WAIT
        press(B_NEXT);
        q_disp.push_back(16'h0001);
        shift_nib(4'h1);
        q_disp.push_back(16'h0000);
        press(B_NEXT);
        q_disp.push_back(16'h0002);
        shift_nib(4'h2);
        q_start.push_back({2'd0, 16'h0001, 16'h0002});
        press(B_NEXT);
        tick(2);
        chk("arst_pre_busy", busy, 1'b1);
        q_disp.push_back(16'h0000);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_busy", busy, 1'b0);
        chk("arst_op1", op1, 16'h0000);
        chk("arst_op2", op2, 16'h0000);
        chk("arst_en", disp_en, 4'hF);
        chk("arst_disp", disp_num, 16'h0000);
        chk("arst_start", alu_start, 1'b0);
        tick(2);
        rst = 1'b0;
        tick(4);

        chk("start_queue_empty", q_start.size(), 0);
        chk("disp_queue_empty", q_disp.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
